// File: rtl/tmds_word_aligner_pkg.sv
// Shared TMDS receive definitions: control tokens, aligner state encoding and
// small helpers used by the word aligner and its window sub-module.
package tmds_word_aligner_pkg;

  localparam int SYM_W = 10;
  localparam int OFF_W = 4;
  localparam int PAIR_W = 2 * SYM_W;
  localparam logic [OFF_W-1:0] OFF_MAX = 4'd9;

  // The four DVI/HDMI control-period tokens, as the encoder emits them.
  localparam logic [SYM_W-1:0] TOK_CTL0 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_CTL1 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_CTL2 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_CTL3 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Counter width for a counter that runs 0..limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic logic is_ctrl_token(input logic [SYM_W-1:0] w);
    return (w == TOK_CTL0) || (w == TOK_CTL1) || (w == TOK_CTL2) || (w == TOK_CTL3);
  endfunction

endpackage

// File: rtl/tmds_bit_window.sv
// Selects a 10-bit symbol window out of two consecutive deserialized words.
// Bit 0 of the pair is the earliest received bit; offset_i picks the first bit.
module tmds_bit_window
  import tmds_word_aligner_pkg::*;
(
  input  logic [SYM_W-1:0] raw_i,
  input  logic [SYM_W-1:0] raw_prev_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic [SYM_W-1:0] win_o
);

  logic [PAIR_W-1:0] pair;

  assign pair = {raw_i, raw_prev_i};

  // Explicit decode keeps the select in range for the unused offsets 10..15.
  always_comb begin
    win_o = pair[9:0];
    case (offset_i)
      4'd0:    win_o = pair[9:0];
      4'd1:    win_o = pair[10:1];
      4'd2:    win_o = pair[11:2];
      4'd3:    win_o = pair[12:3];
      4'd4:    win_o = pair[13:4];
      4'd5:    win_o = pair[14:5];
      4'd6:    win_o = pair[15:6];
      4'd7:    win_o = pair[16:7];
      4'd8:    win_o = pair[17:8];
      4'd9:    win_o = pair[18:9];
      default: win_o = pair[9:0];
    endcase
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: hunts for control-token runs across the ten bit
// offsets, holds lock while tokens keep appearing, emits aligned symbols.
module tmds_word_aligner
  import tmds_word_aligner_pkg::*;
#(
  parameter int RUN_LEN        = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic             clk_px,
  input  logic             reset,
  input  logic [SYM_W-1:0] raw,
  output logic [SYM_W-1:0] cmd,
  output logic             locked,
  output logic [OFF_W-1:0] offset,
  output logic             lock_lost
);

  localparam int RUN_W    = cnt_w(RUN_LEN);
  localparam int SEARCH_W = cnt_w(SEARCH_TIMEOUT);
  localparam int LOSS_W   = cnt_w(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(RUN_LEN - 1);
  localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [SYM_W-1:0]     raw_prev_q;
  logic [SYM_W-1:0]     cmd_q;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [SEARCH_W-1:0]  search_q, search_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 lock_lost_q, lock_lost_d;

  logic [SYM_W-1:0]     win;
  logic                 tok;

  tmds_bit_window u_window (
    .raw_i      (raw),
    .raw_prev_i (raw_prev_q),
    .offset_i   (offset_q),
    .win_o      (win)
  );

  assign tok = is_ctrl_token(win);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    run_d       = run_q;
    search_d    = search_q;
    loss_d      = loss_q;
    lock_lost_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (tok && (run_q == RUN_LAST)) begin
          // Lock takes priority over a slip due in the same cycle.
          state_d  = LOCKED;
          run_d    = '0;
          search_d = '0;
          loss_d   = '0;
        end else begin
          run_d = tok ? run_q + 1'b1 : '0;
          if (search_q == SEARCH_LAST) begin
            offset_d = (offset_q == OFF_MAX) ? '0 : offset_q + 4'd1;
            search_d = '0;
            run_d    = '0;
          end else begin
            search_d = search_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (tok) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          // Offset is kept: the link most likely comes back at the same phase.
          state_d     = SEARCH;
          lock_lost_d = 1'b1;
          run_d       = '0;
          search_d    = '0;
          loss_d      = '0;
        end else begin
          loss_d = loss_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_px or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      raw_prev_q  <= '0;
      cmd_q       <= '0;
      offset_q    <= '0;
      run_q       <= '0;
      search_q    <= '0;
      loss_q      <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      raw_prev_q  <= raw;
      cmd_q       <= win;
      offset_q    <= offset_d;
      run_q       <= run_d;
      search_q    <= search_d;
      loss_q      <= loss_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign cmd       = cmd_q;
  assign locked    = (state_q == LOCKED);
  assign offset    = offset_q;
  assign lock_lost = lock_lost_q;

endmodule
